// File: rtl/scope_trigger_capture.sv
// Per-channel oscilloscope acquisition: circular capture buffer with edge trigger and trigger-aligned readout.
// Optional forced trigger after a WAIT_TRIG timeout, enabled by defining SCOPE_AUTO_TRIG_EN.
module scope_trigger_capture #(
   parameter int unsigned DATA_W       = 12,
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned PRE_TRIG     = 64,
   parameter int unsigned AUTO_TIMEOUT = 4096
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              arm,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [2:0]        state,
   output logic              busy,
   output logic              capture_done,
   output logic              auto_fired
);

   localparam int unsigned     DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] PRE_LAST  = (ADDR_W+1)'(PRE_TRIG - 1);
   localparam logic [ADDR_W:0] POST_LAST = (ADDR_W+1)'(DEPTH - PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRE_TRIG);

   if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 2 || AUTO_TIMEOUT < 1) begin : g_param_check
      $error("scope_trigger_capture: PRE_TRIG or AUTO_TIMEOUT out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PREFILL = 3'd1,
      S_WAIT    = 3'd2,
      S_POST    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W:0]     r_cnt;
   logic [DATA_W-1:0]   r_prev;
   logic [ADDR_W-1:0]   r_trig_addr;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_active;
   logic                w_wr_en;
   logic                w_edge;
   logic                w_fire;
   logic [ADDR_W-1:0]   w_rd_phys;

   assign w_active = (r_state == S_PREFILL) || (r_state == S_WAIT) || (r_state == S_POST);
   assign w_wr_en  = sample_valid && !arm && w_active;

   // Strict crossing: prev must lie strictly on the far side of the level.
   assign w_edge = trig_rising ? ((r_prev < trig_level) && (sample_data >= trig_level))
                               : ((r_prev > trig_level) && (sample_data <= trig_level));

`ifdef SCOPE_AUTO_TRIG_EN
   localparam int unsigned TO_W    = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_auto;

   assign w_fire     = w_edge || (r_to_cnt == TO_LAST);
   assign auto_fired = r_auto;
`else
   assign w_fire     = w_edge;
   assign auto_fired = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_cnt       <= '0;
         r_prev      <= '0;
         r_trig_addr <= '0;
`ifdef SCOPE_AUTO_TRIG_EN
         r_to_cnt    <= '0;
         r_auto      <= 1'b0;
`endif
      end else if (arm) begin
         r_state  <= S_PREFILL;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
`ifdef SCOPE_AUTO_TRIG_EN
         r_to_cnt <= '0;
         r_auto   <= 1'b0;
`endif
      end else if (sample_valid && w_active) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         r_prev   <= sample_data;
         case (r_state)
            S_PREFILL: begin
               if (r_cnt == PRE_LAST) begin
                  r_state <= S_WAIT;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (w_fire) begin
                  r_state     <= S_POST;
                  r_trig_addr <= r_wr_ptr;
                  r_cnt       <= (ADDR_W+1)'(1);
`ifdef SCOPE_AUTO_TRIG_EN
                  r_auto      <= !w_edge;
`endif
               end
`ifdef SCOPE_AUTO_TRIG_EN
               else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            S_POST: begin
               if (r_cnt == POST_LAST) r_state <= S_DONE;
               r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= sample_data;
   end

   assign w_rd_phys = r_trig_addr - PRE_OFS + rd_addr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_data <= '0;
      else          rd_data <= r_mem[w_rd_phys];
   end

   assign state        = r_state;
   assign busy         = w_active;
   assign capture_done = (r_state == S_DONE);

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=20.
module tb_scope_trigger_capture;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] sample_data = '0;
   logic        arm = 1'b0;
   logic [11:0] trig_level = '0;
   logic        trig_rising = 1'b1;
   logic [3:0]  rd_addr = '0;
   logic [11:0] rd_data;
   logic [2:0]  state;
   logic        busy;
   logic        capture_done;
   logic        auto_fired;

   scope_trigger_capture #(
      .DATA_W(12), .ADDR_W(4), .PRE_TRIG(4), .AUTO_TIMEOUT(20)
   ) dut (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising), .rd_addr(rd_addr),
      .rd_data(rd_data), .state(state), .busy(busy), .capture_done(capture_done),
      .auto_fired(auto_fired)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic        arm;
      logic [11:0] data;
      logic [2:0]  exp_state;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   vec_t tbl [23];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic cyc(input logic v, input logic [11:0] d, input logic a);
      sample_valid = v;
      sample_data  = d;
      arm          = a;
      @(posedge clock);
      #1;
      sample_valid = 1'b0;
      arm          = 1'b0;
   endtask

   task automatic feed(input logic [11:0] d);
      cyc(1'b1, d, 1'b0);
   endtask

   task automatic do_arm();
      cyc(1'b0, 12'd0, 1'b1);
   endtask

   task automatic rd(input logic [3:0] a, output int v);
      rd_addr = a;
      @(posedge clock);
      #1;
      v = int'(rd_data);
   endtask

   initial begin
      int v;
      logic [2:0] s;

      // Basic ramp capture: arm, then samples 0..21 with trig_level=10 rising.
      tbl[0] = '{valid: 1'b0, arm: 1'b1, data: 12'd0, exp_state: 3'd1, exp_busy: 1'b1, exp_done: 1'b0};
      for (int i = 0; i < 22; i++) begin
         if (i <= 2)       s = 3'd1;
         else if (i <= 9)  s = 3'd2;
         else if (i <= 20) s = 3'd3;
         else              s = 3'd4;
         tbl[i+1] = '{valid: 1'b1, arm: 1'b0, data: 12'(i), exp_state: s,
                      exp_busy: (s != 3'd4), exp_done: (s == 3'd4)};
      end

      #12;
      chk("reset_state", state, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", capture_done, 0);
      chk("reset_auto", auto_fired, 0);
      chk("reset_rd_data", rd_data, 0);
      reset_n = 1'b1;

      trig_level  = 12'd10;
      trig_rising = 1'b1;
      for (int i = 0; i < 23; i++) begin
         cyc(tbl[i].valid, tbl[i].data, tbl[i].arm);
         chk($sformatf("basic_state[%0d]", i), state, tbl[i].exp_state);
         chk($sformatf("basic_busy[%0d]", i), busy, tbl[i].exp_busy);
         chk($sformatf("basic_done[%0d]", i), capture_done, tbl[i].exp_done);
      end
      for (int k = 0; k < 16; k++) begin
         rd(4'(k), v);
         chk($sformatf("basic_rd[%0d]", k), v, k + 6);
      end

      // Wrap-around: 30 zeros then 100 puts the trigger at physical address 14.
      trig_level = 12'd50;
      do_arm();
      for (int i = 0; i < 30; i++) feed(12'd0);
      chk("wrap_wait", state, 2);
      feed(12'd100);
      chk("wrap_trig", state, 3);
      for (int i = 0; i < 10; i++) feed(12'd200);
      chk("wrap_post", state, 3);
      feed(12'd200);
      chk("wrap_done", state, 4);
      for (int k = 0; k < 4; k++) begin
         rd(4'(k), v);
         chk($sformatf("wrap_rd[%0d]", k), v, 0);
      end
      rd(4'd4, v);  chk("wrap_rd[4]", v, 100);
      rd(4'd5, v);  chk("wrap_rd[5]", v, 200);
      rd(4'd15, v); chk("wrap_rd[15]", v, 200);
      do_arm();
      chk("rearm_from_done_state", state, 1);
      chk("rearm_from_done_flag", capture_done, 0);

      // Falling slope with stalls; stall data (10) would trigger if evaluated.
      trig_rising = 1'b0;
      trig_level  = 12'd50;
      do_arm();
      for (int i = 0; i < 4; i++) feed(12'd90);
      chk("fall_prefilled", state, 2);
      feed(12'd80);            chk("fall_80", state, 2);
      cyc(1'b0, 12'd10, 1'b0);
      feed(12'd60);            chk("fall_60", state, 2);
      cyc(1'b0, 12'd10, 1'b0); chk("fall_stall", state, 2);
      feed(12'd50);            chk("fall_50_trig", state, 3);
      cyc(1'b0, 12'd10, 1'b0);
      feed(12'd40);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 12'd10, 1'b0);
         feed(12'(200 + i));
         if (i == 8) chk("fall_post_before_last", state, 3);
      end
      chk("fall_done", state, 4);
      rd(4'd4, v); chk("fall_rd_trig", v, 50);
      rd(4'd3, v); chk("fall_rd_pre", v, 60);
      rd(4'd5, v); chk("fall_rd_post", v, 40);
      rd(4'd2, v); chk("fall_rd_80", v, 80);
      rd(4'd0, v); chk("fall_rd_oldest", v, 90);

      // Level sitting exactly on the threshold must not trigger.
      trig_rising = 1'b1;
      trig_level  = 12'd50;
      do_arm();
      for (int i = 0; i < 4; i++) feed(12'd50);
      feed(12'd50); chk("eq_50_50", state, 2);
      feed(12'd49); chk("eq_50_49", state, 2);
      feed(12'd50); chk("eq_49_50", state, 3);

      // Re-arm in POST, then async reset in WAIT_TRIG.
      trig_level = 12'd10;
      do_arm();
      for (int i = 0; i <= 12; i++) feed(12'(i));
      chk("rearm_in_post", state, 3);
      do_arm();
      chk("rearm_state", state, 1);
      chk("rearm_done", capture_done, 0);
      chk("rearm_busy", busy, 1);
      for (int i = 0; i < 4; i++) feed(12'(i));
      chk("pre_reset_wait", state, 2);
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset_state", state, 0);
      chk("async_reset_busy", busy, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      chk("reset_held_state", state, 0);

      // Arm and sample_valid together: that sample is dropped, prefill still needs four more.
      cyc(1'b1, 12'd777, 1'b1);
      chk("armvalid_state", state, 1);
      feed(12'd30); feed(12'd31); feed(12'd32);
      chk("armvalid_3_samples", state, 1);
      feed(12'd33);
      chk("armvalid_4_samples", state, 2);

      // Auto trigger: flat signal never crosses the level.
      trig_level = 12'd50;
      do_arm();
      for (int i = 0; i < 4; i++) feed(12'd5);
      for (int i = 0; i < 19; i++) feed(12'd5);
      chk("auto_before_timeout", state, 2);
      feed(12'd5);
`ifdef SCOPE_AUTO_TRIG_EN
      chk("auto_fire_state", state, 3);
      chk("auto_fire_flag", auto_fired, 1);
      for (int i = 0; i < 10; i++) feed(12'd5);
      chk("auto_post", state, 3);
      feed(12'd5);
      chk("auto_done", state, 4);
      chk("auto_done_flag", auto_fired, 1);
`else
      chk("noauto_state", state, 2);
      chk("noauto_flag", auto_fired, 0);
      for (int i = 0; i < 11; i++) feed(12'd5);
      chk("noauto_still_wait", state, 2);
      chk("noauto_flag_late", auto_fired, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
